hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Hazard and forwarding controller for the 5-stage ARM pipeline of the image-equalizer core.
- Consumes the datapath's 5-bit register-match vector plus decode-stage control bits.
- Keeps its own shadow pipeline of RegWrite/MemtoReg/PCSrc for stages E/M/W.
- Drives ForwardAE/ForwardBE and stallF/stallD/flushD/flushE back into the datapath, and keeps saturating stall/flush performance counters.

Parameters:
CNT_W, 16, width of the performance counters (saturating)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
match  input  5  {match_12d_e, match_1e_m, match_2e_m, match_1e_w, match_2e_w} from datapath
RegWriteD  input  1  instruction in D writes the register file
MemtoRegD  input  1  instruction in D is a load (result from memory)
PCSrcD  input  1  instruction in D writes R15 (non-branch PC write)
cond_ex_e  input  1  condition of instruction in E passed
BranchTakenE  input  1  branch resolved taken in E
ForwardAE  output  2  SrcA forward select: 00 RD1E, 01 ResultW, 10 ALUOutM
ForwardBE  output  2  SrcB/WriteData forward select, same encoding
stallF  output  1  hold PC register
stallD  output  1  hold F->D register
flushD  output  1  clear F->D register
flushE  output  1  clear D->E register
PCSrcW  output  1  shadow PC-write in W (for the PC mux)
stall_cnt  output  CNT_W  cycles with stallF=1
flush_cnt  output  CNT_W  cycles with flushD=1 or flushE=1
clr_cnt  input  1  synchronous clear of both counters

Behaviour:
- Reset (reset=0, async): all shadow bits (RegWriteE/M/W, MemtoRegE, PCSrcE/M/W) = 0; counters = 0.
  - Consequence: ForwardAE=ForwardBE=00 and all stall/flush = 0 while in reset.
- Shadow pipeline, updated on the clk rising edge:
  - E <- D inputs, or 0 if flushE is 1 this cycle.
  - M <- E, with RegWriteE and PCSrcE ANDed with cond_ex_e.
  - W <- M.
  - E/M/W are never stalled; only F and D stall.
- Forwarding (combinational from match and shadow state, zero latency):
  - ForwardAE = 10 if match[3] & RegWriteM; else 01 if match[1] & RegWriteW; else 00. M has priority over W.
  - ForwardBE uses the same rule with match[2] and match[0].
- Stall and flush logic (combinational):
  - ldrStall = match[4] & MemtoRegE.
  - PCWrPending = PCSrcD | PCSrcE | PCSrcM.
  - stallF = ldrStall | PCWrPending.
  - stallD = ldrStall.
  - flushD = PCWrPending | PCSrcW | BranchTakenE.
  - flushE = ldrStall | BranchTakenE.
- Simultaneous events:
  - ldrStall and BranchTakenE together: branch wins for D (flushD=1); stallD stays 1 but the datapath's flush takes precedence; flushE=1.
  - A flushed E slot carries no RegWrite, so it never produces a forward or ldrStall next cycle.
- PC write in flight: stallF is held from PCSrcD until PCSrcM clears, i.e. 3 cycles for an uninterrupted R15 write. flushD stays asserted through W.
- Counters:
  - Saturate at all-ones; never wrap.
  - clr_cnt has priority over increment.
  - Reset mid-operation clears the counters and the shadow pipeline immediately.
- No handshake: one instruction per stage per cycle; outputs are valid every cycle after reset deasserts.

Test Plan:
- ALU->ALU forwarding: RegWriteD=1 for ADD R1, next instr uses R1 as Rn; match=5'b01000 with RegWriteM=1 -> ForwardAE=10 and ForwardBE=00, with no stall.
- Double match priority: match=5'b01010, RegWriteM=RegWriteW=1 -> ForwardAE=10. With RegWriteM=0 -> ForwardAE=01.
- Load-use: MemtoRegD=RegWriteD=1, next cycle match[4]=1 -> exactly one cycle of stallF=stallD=flushE=1. The following cycle ForwardAE=01 via the W stage. stall_cnt increments by 1.
- R15 write: PCSrcD=1 for one cycle -> stallF=1 for 3 cycles, flushD=1 for 4 cycles, PCSrcW=1 in cycle 4. Repeat with cond_ex_e=0 -> stallF drops after 2 cycles and PCSrcW never rises.
- Taken branch: BranchTakenE=1 -> flushD=flushE=1 in the same cycle. RegWriteE=0 next cycle, so no forward is produced from the squashed slot. flush_cnt increments by 1.
- Counter saturation, clear and reset: CNT_W=4, hold stall for 20 cycles -> stall_cnt=15. Pulse clr_cnt during stall -> 0. Assert reset mid-stall -> all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Hazard and forwarding controller for the 5-stage ARM pipeline.
// Tracks RegWrite/MemtoReg/PCSrc through shadow E/M/W stages and derives
// forwarding selects, stall/flush controls and saturating event counters.
module hazard_control_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       match,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             PCSrcD,
    input  logic             cond_ex_e,
    input  logic             BranchTakenE,
    input  logic             clr_cnt,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic             PCSrcW,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // match bit positions
    localparam int unsigned Match12DE = 4;
    localparam int unsigned Match1EM  = 3;
    localparam int unsigned Match2EM  = 2;
    localparam int unsigned Match1EW  = 1;
    localparam int unsigned Match2EW  = 0;

    localparam logic [1:0] FwdRd1    = 2'b00;
    localparam logic [1:0] FwdResult = 2'b01;
    localparam logic [1:0] FwdAluOut = 2'b10;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic reg_write_e_q, reg_write_m_q, reg_write_w_q;
    logic mem_to_reg_e_q;
    logic pc_src_e_q, pc_src_m_q, pc_src_w_q;
    logic reg_write_e_d, reg_write_m_d, reg_write_w_d;
    logic mem_to_reg_e_d;
    logic pc_src_e_d, pc_src_m_d, pc_src_w_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic ldr_stall;
    logic pc_wr_pending;

    // Forwarding selects and stall/flush controls; all forced low while in reset.
    always_comb begin
        ForwardAE     = FwdRd1;
        ForwardBE     = FwdRd1;
        stallF        = 1'b0;
        stallD        = 1'b0;
        flushD        = 1'b0;
        flushE        = 1'b0;
        ldr_stall     = 1'b0;
        pc_wr_pending = 1'b0;
        if (reset) begin
            // M stage holds the newer result, so it wins over W
            if (match[Match1EM] && reg_write_m_q) begin
                ForwardAE = FwdAluOut;
            end else if (match[Match1EW] && reg_write_w_q) begin
                ForwardAE = FwdResult;
            end
            if (match[Match2EM] && reg_write_m_q) begin
                ForwardBE = FwdAluOut;
            end else if (match[Match2EW] && reg_write_w_q) begin
                ForwardBE = FwdResult;
            end
            ldr_stall     = match[Match12DE] && mem_to_reg_e_q;
            pc_wr_pending = PCSrcD || pc_src_e_q || pc_src_m_q;
            stallF        = ldr_stall || pc_wr_pending;
            stallD        = ldr_stall;
            flushD        = pc_wr_pending || pc_src_w_q || BranchTakenE;
            flushE        = ldr_stall || BranchTakenE;
        end
    end

    // Next state of the shadow pipeline; E/M/W always advance, E takes a bubble on flushE.
    always_comb begin
        reg_write_e_d  = RegWriteD;
        mem_to_reg_e_d = MemtoRegD;
        pc_src_e_d     = PCSrcD;
        if (flushE) begin
            reg_write_e_d  = 1'b0;
            mem_to_reg_e_d = 1'b0;
            pc_src_e_d     = 1'b0;
        end
        // a failed condition in E cancels its architectural effects
        reg_write_m_d = reg_write_e_q && cond_ex_e;
        pc_src_m_d    = pc_src_e_q && cond_ex_e;
        reg_write_w_d = reg_write_m_q;
        pc_src_w_d    = pc_src_m_q;
    end

    // Next state of the saturating counters; clear beats increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stallF && (stall_cnt_q != CntMax)) begin
                stall_cnt_d = stall_cnt_q + CntOne;
            end
            if ((flushD || flushE) && (flush_cnt_q != CntMax)) begin
                flush_cnt_d = flush_cnt_q + CntOne;
            end
        end
    end

    // State registers for the shadow pipeline and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_e_q  <= 1'b0;
            reg_write_m_q  <= 1'b0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_e_q <= 1'b0;
            pc_src_e_q     <= 1'b0;
            pc_src_m_q     <= 1'b0;
            pc_src_w_q     <= 1'b0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
        end else begin
            reg_write_e_q  <= reg_write_e_d;
            reg_write_m_q  <= reg_write_m_d;
            reg_write_w_q  <= reg_write_w_d;
            mem_to_reg_e_q <= mem_to_reg_e_d;
            pc_src_e_q     <= pc_src_e_d;
            pc_src_m_q     <= pc_src_m_d;
            pc_src_w_q     <= pc_src_w_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign PCSrcW    = pc_src_w_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: hand-derived vector table,
// directed multi-cycle sequences, and random stimulus against a slot-level model.
module tb_hazard_control_unit;

    localparam int CNT_W  = 4;
    localparam int CntMax = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic [4:0]       match;
    logic             RegWriteD, MemtoRegD, PCSrcD, cond_ex_e, BranchTakenE, clr_cnt;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             stallF, stallD, flushD, flushE, PCSrcW;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_control_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .match        (match),
        .RegWriteD    (RegWriteD),
        .MemtoRegD    (MemtoRegD),
        .PCSrcD       (PCSrcD),
        .cond_ex_e    (cond_ex_e),
        .BranchTakenE (BranchTakenE),
        .clr_cnt      (clr_cnt),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .stallF       (stallF),
        .stallD       (stallD),
        .flushD       (flushD),
        .flushE       (flushE),
        .PCSrcW       (PCSrcW),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: instruction slots in E, M, W ----------------
    typedef struct packed {
        logic rw;
        logic mtr;
        logic pcs;
    } slot_t;

    slot_t pipe [3];  // 0=E, 1=M, 2=W
    int    m_stall, m_flush;
    int    e_fa, e_fb, e_sf, e_sd, e_fd, e_fe, e_pw;

    function automatic int fwd(input logic hit_m, input logic hit_w, input slot_t sm,
                               input slot_t sw);
        if (hit_m && sm.rw) return 2;
        if (hit_w && sw.rw) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic model_eval();
        int load_use, pc_pending;
        e_fa = 0; e_fb = 0; e_sf = 0; e_sd = 0; e_fd = 0; e_fe = 0;
        e_pw = int'(pipe[2].pcs);
        if (reset) begin
            e_fa       = fwd(match[3], match[1], pipe[1], pipe[2]);
            e_fb       = fwd(match[2], match[0], pipe[1], pipe[2]);
            load_use   = int'(match[4] && pipe[0].mtr);
            pc_pending = int'(PCSrcD || pipe[0].pcs || pipe[1].pcs);
            e_sf = (load_use != 0 || pc_pending != 0) ? 1 : 0;
            e_sd = load_use;
            e_fd = (pc_pending != 0 || pipe[2].pcs || BranchTakenE) ? 1 : 0;
            e_fe = (load_use != 0 || BranchTakenE) ? 1 : 0;
        end
    endtask

    task automatic model_clock();
        slot_t d_slot;
        if (!reset) begin
            model_reset();
            return;
        end
        d_slot  = '{rw: RegWriteD, mtr: MemtoRegD, pcs: PCSrcD};
        pipe[2] = pipe[1];
        pipe[1] = '{rw: pipe[0].rw & cond_ex_e, mtr: pipe[0].mtr, pcs: pipe[0].pcs & cond_ex_e};
        pipe[0] = (e_fe != 0) ? slot_t'('0) : d_slot;
        if (clr_cnt) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (e_sf != 0 && m_stall < CntMax) m_stall++;
            if ((e_fd != 0 || e_fe != 0) && m_flush < CntMax) m_flush++;
        end
    endtask

    task automatic check_model();
        chk("ForwardAE", int'(ForwardAE), e_fa);
        chk("ForwardBE", int'(ForwardBE), e_fb);
        chk("stallF", int'(stallF), e_sf);
        chk("stallD", int'(stallD), e_sd);
        chk("flushD", int'(flushD), e_fd);
        chk("flushE", int'(flushE), e_fe);
        chk("PCSrcW", int'(PCSrcW), e_pw);
        chk("stall_cnt", int'(stall_cnt), m_stall);
        chk("flush_cnt", int'(flush_cnt), m_flush);
    endtask

    // Drive inputs one step after the edge, settle, compare against the model.
    task automatic apply(input logic [4:0] m, input logic rwd, input logic mtrd,
                         input logic pcsd, input logic cond, input logic bt, input logic clr);
        match = m; RegWriteD = rwd; MemtoRegD = mtrd; PCSrcD = pcsd;
        cond_ex_e = cond; BranchTakenE = bt; clr_cnt = clr;
        #1;
        model_eval();
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    // ---------------- hand-derived vector table ----------------
    typedef struct packed {
        logic [4:0] m;
        logic       rwd, mtrd, pcsd, cond, bt;
        logic [1:0] fa, fb;
        logic       sf, sd, fd, fe;
    } vec_t;

    function automatic vec_t mkv(input logic [4:0] m, input logic rwd, input logic mtrd,
                                 input logic pcsd, input logic cond, input logic bt,
                                 input logic [1:0] fa, input logic [1:0] fb, input logic sf,
                                 input logic sd, input logic fd, input logic fe);
        vec_t v;
        v.m = m; v.rwd = rwd; v.mtrd = mtrd; v.pcsd = pcsd; v.cond = cond; v.bt = bt;
        v.fa = fa; v.fb = fb; v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe;
        return v;
    endfunction

    vec_t vecs [18];

    initial begin
        logic [4:0] exp_sf, exp_fd, exp_pw;

        //               match     rwd  mtr  pcs  cnd  bt    fa     fb    sf sd fd fe
        vecs[0]  = mkv(5'b00000, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0); // ADD R1
        vecs[1]  = mkv(5'b00000, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        vecs[2]  = mkv(5'b01000, 1, 0, 0, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0); // M fwd A
        vecs[3]  = mkv(5'b01010, 1, 0, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0); // M empty, W
        vecs[4]  = mkv(5'b01111, 0, 0, 0, 1, 0, 2'b10, 2'b10, 0, 0, 0, 0); // M only
        vecs[5]  = mkv(5'b01010, 0, 0, 0, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0); // M beats W
        vecs[6]  = mkv(5'b00001, 0, 0, 0, 1, 0, 2'b00, 2'b01, 0, 0, 0, 0); // W fwd B
        vecs[7]  = mkv(5'b00000, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0); // LDR
        vecs[8]  = mkv(5'b10000, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 1); // load-use
        vecs[9]  = mkv(5'b00000, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        vecs[10] = mkv(5'b00010, 0, 0, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0); // load via W
        vecs[11] = mkv(5'b00000, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        vecs[12] = mkv(5'b00000, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 1, 1); // branch
        vecs[13] = mkv(5'b11111, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        vecs[14] = mkv(5'b11111, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0); // squashed
        vecs[15] = mkv(5'b00000, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);
        vecs[16] = mkv(5'b10000, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 1, 1, 1); // ldr+branch
        vecs[17] = mkv(5'b01010, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0);

        // reset state
        reset = 1'b0;
        model_reset();
        apply(5'b11111, 1, 1, 0, 1, 0, 0);
        chk("rst_ForwardAE", int'(ForwardAE), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        advance();
        advance();
        reset = 1'b1;

        // table
        for (int i = 0; i < 18; i++) begin
            apply(vecs[i].m, vecs[i].rwd, vecs[i].mtrd, vecs[i].pcsd, vecs[i].cond,
                  vecs[i].bt, 0);
            chk($sformatf("vec%0d_ForwardAE", i), int'(ForwardAE), int'(vecs[i].fa));
            chk($sformatf("vec%0d_ForwardBE", i), int'(ForwardBE), int'(vecs[i].fb));
            chk($sformatf("vec%0d_stallF", i), int'(stallF), int'(vecs[i].sf));
            chk($sformatf("vec%0d_stallD", i), int'(stallD), int'(vecs[i].sd));
            chk($sformatf("vec%0d_flushD", i), int'(flushD), int'(vecs[i].fd));
            chk($sformatf("vec%0d_flushE", i), int'(flushE), int'(vecs[i].fe));
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            apply(5'b00000, 0, 0, 0, 1, 0, 0);
            advance();
        end

        // R15 write, condition passes
        apply(5'b00000, 0, 0, 0, 1, 0, 1);
        advance();
        exp_sf = 5'b00111;
        exp_fd = 5'b01111;
        exp_pw = 5'b01000;
        for (int i = 0; i < 5; i++) begin
            apply(5'b00000, 0, 0, (i == 0), 1, 0, 0);
            chk($sformatf("r15_stallF_c%0d", i), int'(stallF), int'(exp_sf[i]));
            chk($sformatf("r15_flushD_c%0d", i), int'(flushD), int'(exp_fd[i]));
            chk($sformatf("r15_PCSrcW_c%0d", i), int'(PCSrcW), int'(exp_pw[i]));
            advance();
        end
        chk("r15_stall_cnt", int'(stall_cnt), 3);
        chk("r15_flush_cnt", int'(flush_cnt), 4);

        // R15 write, condition fails in E
        exp_sf = 5'b00011;
        exp_fd = 5'b00011;
        for (int i = 0; i < 5; i++) begin
            apply(5'b00000, 0, 0, (i == 0), (i != 1), 0, 0);
            chk($sformatf("r15nc_stallF_c%0d", i), int'(stallF), int'(exp_sf[i]));
            chk($sformatf("r15nc_flushD_c%0d", i), int'(flushD), int'(exp_fd[i]));
            chk($sformatf("r15nc_PCSrcW_c%0d", i), int'(PCSrcW), 0);
            advance();
        end

        // saturation, clear during stall, async reset mid-stall
        apply(5'b00000, 0, 0, 0, 1, 0, 1);
        advance();
        for (int i = 0; i < 20; i++) begin
            apply(5'b00000, 0, 0, 1, 1, 0, 0);
            advance();
        end
        chk("sat_stall_cnt", int'(stall_cnt), CntMax);
        chk("sat_flush_cnt", int'(flush_cnt), CntMax);
        apply(5'b00000, 0, 0, 1, 1, 0, 1);
        advance();
        chk("clr_stall_cnt", int'(stall_cnt), 0);
        for (int i = 0; i < 2; i++) begin
            apply(5'b00000, 0, 0, 1, 1, 0, 0);
            advance();
        end
        chk("pre_rst_stall_cnt", int'(stall_cnt), 2);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_stallF", int'(stallF), 0);
        chk("arst_flushD", int'(flushD), 0);
        chk("arst_PCSrcW", int'(PCSrcW), 0);
        chk("arst_stall_cnt", int'(stall_cnt), 0);
        chk("arst_flush_cnt", int'(flush_cnt), 0);
        model_reset();
        advance();
        apply(5'b11111, 1, 1, 1, 1, 1, 0);
        advance();
        reset = 1'b1;

        // random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            apply(5'($urandom), 1'($urandom % 2), ($urandom % 3) == 0, ($urandom % 8) == 0,
                  ($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 40) == 0);
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
